cnn_layer_accel_job_dispatcher: RTL and testbench
=================================================

CNN_LAYER_ACCEL_JOB_DISPATCHER -- requirements
Module: cnn_layer_accel_job_dispatcher

Interface
REQ-001 Parameter NUM_QUADS, default 4, number of quads served (1..16).
REQ-002 Parameter PARAM_W, default 128, job parameter word width.
REQ-003 Parameter QID_W, default max(1,clog2(NUM_QUADS)), quad index width.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Ports SHALL be, one per line, as follows:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- job_in_valid  in  1  upstream job offered
- job_in_ready  out  1  dispatcher takes job this cycle
- job_in_data  in  PARAM_W  job parameters
- job_start  out  NUM_QUADS  per-quad start request
- job_accept  in  NUM_QUADS  per-quad start acknowledge
- job_parameters  out  NUM_QUADS*PARAM_W  per-quad parameter word, slice q = quad q
- job_fetch_request  in  NUM_QUADS  quad requests data fetch
- job_fetch_ack  out  NUM_QUADS  one-cycle fetch grant pulse
- job_fetch_complete  out  NUM_QUADS  one-cycle fetch finished pulse
- job_complete  in  NUM_QUADS  quad finished job
- job_complete_ack  out  NUM_QUADS  one-cycle completion ack pulse
- fetch_req_valid  out  1  fetch engine owns transfer for fetch_req_quad
- fetch_req_quad  out  QID_W  quad index being fetched
- fetch_done  in  1  fetch engine finished current transfer
- busy  out  1  any quad not IDLE
- jobs_done_count  out  32  completed jobs since reset

Function
REQ-006 Each quad SHALL have an independent FSM: IDLE, START, RUN, FETCH, ACK.
REQ-007 job_in_ready SHALL be 1 exactly when at least one quad is IDLE.
REQ-008 On job_in_valid&&job_in_ready, job SHALL go to the first IDLE quad at/after the round-robin dispatch pointer; pointer then advances to that quad+1 mod NUM_QUADS.
REQ-009 Dispatched quad SHALL latch job_in_data into its job_parameters slice and enter START next cycle.
REQ-010 In START, job_start[q] SHALL be 1 and job_parameters slice stable until the cycle job_accept[q]=1; next state RUN.
REQ-011 job_accept[q] outside START SHALL be ignored.
REQ-012 One fetch channel SHALL be shared; among quads in RUN with job_fetch_request=1, grant SHALL be round-robin, at most one grant when fetch_req_valid=0.
REQ-013 Grant cycle: job_fetch_ack[q] pulses 1 cycle, quad enters FETCH, fetch_req_valid=1 and fetch_req_quad=q from next cycle.
REQ-014 fetch_req_valid SHALL hold until fetch_done=1; that cycle job_fetch_complete[q] pulses next cycle, quad returns to RUN, fetch_req_valid drops.
REQ-015 A new grant SHALL NOT issue in the same cycle fetch_done is seen (minimum one idle cycle between transfers).
REQ-016 fetch_done with fetch_req_valid=0 SHALL be ignored.
REQ-017 In RUN, job_complete[q]=1 SHALL move quad to ACK; job_complete_ack[q] pulses 1 cycle; next state IDLE.
REQ-018 job_complete[q] and job_fetch_request[q] both 1 in RUN: completion wins, no grant.
REQ-019 job_complete[q] in FETCH SHALL be held off; it is acted on only after return to RUN.
REQ-020 jobs_done_count SHALL increment by 1 per ACK entry; multiple quads same cycle add popcount; wraps at 2^32.
REQ-021 Dispatch and completion in the same cycle SHALL NOT let a quad freed that cycle receive the job; it becomes eligible next cycle.
REQ-022 busy SHALL be combinational OR of all quads != IDLE.

Reset
REQ-023 rst=0 SHALL immediately force all FSMs to IDLE, both round-robin pointers to 0, all pulse/request outputs to 0, job_parameters to 0, jobs_done_count to 0, fetch_req_valid 0, fetch_req_quad 0.
REQ-024 Reset mid-fetch SHALL drop fetch_req_valid without a job_fetch_complete pulse.
REQ-025 Deassertion SHALL be synchronised internally; first dispatch possible on second rising edge after rst rises.

Verification
REQ-026 NUM_QUADS=4, push 4 jobs back-to-back, params 0x11..0x44 -> quads 0..3 get 0x11..0x44 in order, job_in_ready=0 after 4th.
REQ-027 Quads 1 and 2 raise job_fetch_request same cycle, pointer at 0 -> quad 1 acked first, fetch_req_quad=1; after fetch_done, one idle cycle, then quad 2 acked.
REQ-028 Quad 0 in RUN asserts job_complete and job_fetch_request together -> job_complete_ack[0] pulse, no fetch ack, jobs_done_count 0->1.
REQ-029 Quad 3 job_accept held low 10 cycles -> job_start[3]=1 and parameters stable all 10 cycles, RUN after accept.
REQ-030 rst=0 asserted while fetch_req_valid=1 -> all outputs 0 same cycle, no job_fetch_complete, count 0.
REQ-031 NUM_QUADS=1, job_complete and new job_in_valid same cycle -> job_in_ready=0 that cycle, job accepted next cycle.

Source files
------------

// File: rtl/cnn_layer_accel_job_dispatcher_if.sv
// Handshake bundle between the CNN layer job dispatcher, its compute quads and
// the shared fetch engine. "master" is the dispatcher side, "slave" the environment.
interface cnn_layer_accel_job_dispatcher_if #(
    parameter int NUM_QUADS = 4,
    parameter int PARAM_W   = 128,
    parameter int QID_W     = (NUM_QUADS > 1) ? $clog2(NUM_QUADS) : 1
);
    logic                         job_in_valid;
    logic                         job_in_ready;
    logic [PARAM_W-1:0]           job_in_data;
    logic [NUM_QUADS-1:0]         job_start;
    logic [NUM_QUADS-1:0]         job_accept;
    logic [NUM_QUADS*PARAM_W-1:0] job_parameters;
    logic [NUM_QUADS-1:0]         job_fetch_request;
    logic [NUM_QUADS-1:0]         job_fetch_ack;
    logic [NUM_QUADS-1:0]         job_fetch_complete;
    logic [NUM_QUADS-1:0]         job_complete;
    logic [NUM_QUADS-1:0]         job_complete_ack;
    logic                         fetch_req_valid;
    logic [QID_W-1:0]             fetch_req_quad;
    logic                         fetch_done;
    logic                         busy;
    logic [31:0]                  jobs_done_count;

    modport master (
        input  job_in_valid, job_in_data, job_accept, job_fetch_request,
               job_complete, fetch_done,
        output job_in_ready, job_start, job_parameters, job_fetch_ack,
               job_fetch_complete, job_complete_ack, fetch_req_valid,
               fetch_req_quad, busy, jobs_done_count
    );

    modport slave (
        output job_in_valid, job_in_data, job_accept, job_fetch_request,
               job_complete, fetch_done,
        input  job_in_ready, job_start, job_parameters, job_fetch_ack,
               job_fetch_complete, job_complete_ack, fetch_req_valid,
               fetch_req_quad, busy, jobs_done_count
    );
endinterface

// File: rtl/cnn_layer_accel_job_dispatcher.sv
// Dispatches layer jobs round-robin onto NUM_QUADS compute quads and arbitrates
// a single shared fetch channel between them.
//   state   | meaning
//   S_IDLE  | quad free, may receive a job
//   S_START | job latched, job_start high until the quad accepts
//   S_RUN   | quad computing; may request a fetch or report completion
//   S_FETCH | quad owns the fetch channel until fetch_done
//   S_ACK   | completion acknowledged; quad is free from the next cycle
module cnn_layer_accel_job_dispatcher #(
    parameter int NUM_QUADS = 4,
    parameter int PARAM_W   = 128,
    parameter int QID_W     = (NUM_QUADS > 1) ? $clog2(NUM_QUADS) : 1
) (
    input logic clk,
    input logic rst,
    cnn_layer_accel_job_dispatcher_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_FETCH,
        S_ACK
    } quad_state_e;

    quad_state_e                  state_q [NUM_QUADS];
    logic                         rst_sync_q;
    logic [QID_W-1:0]             disp_ptr_q;
    logic [QID_W-1:0]             fetch_ptr_q;
    logic [QID_W-1:0]             fetch_quad_q;
    logic                         fetch_valid_q;
    logic [NUM_QUADS-1:0]         job_start_q;
    logic [NUM_QUADS-1:0]         fetch_ack_q;
    logic [NUM_QUADS-1:0]         fetch_cmpl_q;
    logic [NUM_QUADS-1:0]         cmpl_ack_q;
    logic [NUM_QUADS*PARAM_W-1:0] params_q;
    logic [31:0]                  count_q;
    logic [31:0]                  count_d;

    logic [NUM_QUADS-1:0]         idle_vec;
    logic [NUM_QUADS-1:0]         retire_vec;
    logic [NUM_QUADS-1:0]         grant_cand;
    logic                         disp_hit;
    logic                         grant_hit;
    logic                         disp_fire;
    logic [QID_W-1:0]             disp_idx;
    logic [QID_W-1:0]             grant_idx;
    logic [QID_W-1:0]             disp_ptr_d;
    logic [QID_W-1:0]             fetch_ptr_d;

    // Assertion is immediate; release reaches the core one clock after rst rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 1'b0;
        else      rst_sync_q <= 1'b1;
    end

    always_comb begin
        idle_vec   = '0;
        retire_vec = '0;
        grant_cand = '0;
        for (int q = 0; q < NUM_QUADS; q++) begin
            idle_vec[q]   = (state_q[q] == S_IDLE);
            retire_vec[q] = (state_q[q] == S_RUN) && bus.job_complete[q];
            // completion beats a simultaneous fetch request
            grant_cand[q] = (state_q[q] == S_RUN) && bus.job_fetch_request[q]
                            && !bus.job_complete[q];
        end
    end

    always_comb begin
        int               k;
        logic [QID_W-1:0] kq;
        k           = 0;
        kq          = '0;
        disp_hit    = 1'b0;
        disp_idx    = '0;
        disp_ptr_d  = disp_ptr_q;
        grant_hit   = 1'b0;
        grant_idx   = '0;
        fetch_ptr_d = fetch_ptr_q;
        for (int i = 0; i < NUM_QUADS; i++) begin
            k  = (int'(disp_ptr_q) + i) % NUM_QUADS;
            kq = QID_W'(k);
            if (!disp_hit && idle_vec[kq]) begin
                disp_hit   = 1'b1;
                disp_idx   = kq;
                disp_ptr_d = QID_W'((k + 1) % NUM_QUADS);
            end
        end
        for (int i = 0; i < NUM_QUADS; i++) begin
            k  = (int'(fetch_ptr_q) + i) % NUM_QUADS;
            kq = QID_W'(k);
            if (!fetch_valid_q && !grant_hit && grant_cand[kq]) begin
                grant_hit   = 1'b1;
                grant_idx   = kq;
                fetch_ptr_d = QID_W'((k + 1) % NUM_QUADS);
            end
        end
    end

    assign disp_fire = bus.job_in_valid && bus.job_in_ready && disp_hit;
    assign count_d   = count_q + 32'($countones(retire_vec));

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            for (int q = 0; q < NUM_QUADS; q++) state_q[q] <= S_IDLE;
            disp_ptr_q    <= '0;
            fetch_ptr_q   <= '0;
            fetch_quad_q  <= '0;
            fetch_valid_q <= 1'b0;
            job_start_q   <= '0;
            fetch_ack_q   <= '0;
            fetch_cmpl_q  <= '0;
            cmpl_ack_q    <= '0;
            params_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_ack_q  <= '0;
            fetch_cmpl_q <= '0;
            cmpl_ack_q   <= '0;
            count_q      <= count_d;
            if (disp_fire) disp_ptr_q <= disp_ptr_d;
            if (grant_hit) begin
                fetch_ptr_q   <= fetch_ptr_d;
                fetch_valid_q <= 1'b1;
                fetch_quad_q  <= grant_idx;
            end else if (fetch_valid_q && bus.fetch_done) begin
                fetch_valid_q <= 1'b0;
            end
            for (int q = 0; q < NUM_QUADS; q++) begin
                case (state_q[q])
                    S_IDLE: begin
                        if (disp_fire && disp_idx == QID_W'(q)) begin
                            params_q[q*PARAM_W +: PARAM_W] <= bus.job_in_data;
                            job_start_q[q] <= 1'b1;
                            state_q[q]     <= S_START;
                        end
                    end
                    S_START: begin
                        if (bus.job_accept[q]) begin
                            job_start_q[q] <= 1'b0;
                            state_q[q]     <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (bus.job_complete[q]) begin
                            cmpl_ack_q[q] <= 1'b1;
                            state_q[q]    <= S_ACK;
                        end else if (grant_hit && grant_idx == QID_W'(q)) begin
                            fetch_ack_q[q] <= 1'b1;
                            state_q[q]     <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (fetch_valid_q && bus.fetch_done) begin
                            fetch_cmpl_q[q] <= 1'b1;
                            state_q[q]      <= S_RUN;
                        end
                    end
                    S_ACK:   state_q[q] <= S_IDLE;
                    default: state_q[q] <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.job_in_ready       = rst_sync_q && (|idle_vec);
    assign bus.busy               = ~(&idle_vec);
    assign bus.job_start          = job_start_q;
    assign bus.job_parameters     = params_q;
    assign bus.job_fetch_ack      = fetch_ack_q;
    assign bus.job_fetch_complete = fetch_cmpl_q;
    assign bus.job_complete_ack   = cmpl_ack_q;
    assign bus.fetch_req_valid    = fetch_valid_q;
    assign bus.fetch_req_quad     = fetch_quad_q;
    assign bus.jobs_done_count    = count_q;
endmodule

// File: tb/tb_cnn_layer_accel_job_dispatcher.sv
// Bench for the job dispatcher: directed vectors and corner sequences, then
// random traffic against a job-level reference model.
module tb_cnn_layer_accel_job_dispatcher;
    localparam int NQ  = 4;
    localparam int PW  = 128;
    localparam int PW1 = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnn_layer_accel_job_dispatcher_if #(.NUM_QUADS(NQ), .PARAM_W(PW))  bus4 ();
    cnn_layer_accel_job_dispatcher_if #(.NUM_QUADS(1),  .PARAM_W(PW1)) bus1 ();

    cnn_layer_accel_job_dispatcher #(.NUM_QUADS(NQ), .PARAM_W(PW)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );
    cnn_layer_accel_job_dispatcher #(.NUM_QUADS(1), .PARAM_W(PW1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       exp_ready;
        logic [3:0] exp_start;
    } disp_vec_t;
    disp_vec_t vecs [5];

    // reference model: per-quad job bookkeeping
    bit            m_has     [NQ];
    bit            m_started [NQ];
    bit            m_infetch [NQ];
    bit            m_retire  [NQ];
    logic [PW-1:0] m_param   [NQ];
    bit [NQ-1:0]   m_fack, m_fcmpl, m_cack;
    int            m_owner, m_fquad, m_dptr, m_fptr;
    logic [31:0]   m_count;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus4.job_in_valid = 1'b0; bus4.job_in_data = '0; bus4.job_accept = '0;
        bus4.job_fetch_request = '0; bus4.job_complete = '0; bus4.fetch_done = 1'b0;
        bus1.job_in_valid = 1'b0; bus1.job_in_data = '0; bus1.job_accept = '0;
        bus1.job_fetch_request = '0; bus1.job_complete = '0; bus1.fetch_done = 1'b0;
    endtask

    function automatic bit working(input int q);
        return m_has[q] && m_started[q] && !m_infetch[q] && !m_retire[q];
    endfunction

    task automatic model_reset();
        for (int q = 0; q < NQ; q++) begin
            m_has[q] = 0; m_started[q] = 0; m_infetch[q] = 0; m_retire[q] = 0;
            m_param[q] = '0;
        end
        m_fack = '0; m_fcmpl = '0; m_cack = '0;
        m_owner = -1; m_fquad = 0; m_dptr = 0; m_fptr = 0; m_count = '0;
    endtask

    task automatic model_step(input bit iv, input logic [PW-1:0] idata, input bit [NQ-1:0] acc,
                              input bit [NQ-1:0] frq, input bit [NQ-1:0] cmp, input bit fdn);
        bit n_has     [NQ];
        bit n_started [NQ];
        bit n_infetch [NQ];
        bit n_retire  [NQ];
        bit any_free;
        int pick;
        int c;
        any_free = 1'b0;
        m_fack = '0; m_fcmpl = '0; m_cack = '0;
        for (int q = 0; q < NQ; q++) begin
            n_has[q] = m_has[q]; n_started[q] = m_started[q];
            n_infetch[q] = m_infetch[q]; n_retire[q] = m_retire[q];
            if (!m_has[q]) any_free = 1'b1;
            if (m_retire[q]) begin
                n_has[q] = 1'b0;
                n_retire[q] = 1'b0;
            end
        end
        if (iv && any_free) begin
            pick = -1;
            for (int i = 0; i < NQ; i++) begin
                c = (m_dptr + i) % NQ;
                if (pick < 0 && !m_has[c]) pick = c;
            end
            n_has[pick] = 1'b1; n_started[pick] = 1'b0;
            m_param[pick] = idata;
            m_dptr = (pick + 1) % NQ;
        end
        for (int q = 0; q < NQ; q++) begin
            if (m_has[q] && !m_started[q] && acc[q]) n_started[q] = 1'b1;
            if (working(q) && cmp[q]) begin
                n_retire[q] = 1'b1;
                m_cack[q] = 1'b1;
                m_count = m_count + 32'd1;
            end
        end
        if (m_owner < 0) begin
            pick = -1;
            for (int i = 0; i < NQ; i++) begin
                c = (m_fptr + i) % NQ;
                if (pick < 0 && working(c) && frq[c] && !cmp[c]) pick = c;
            end
            if (pick >= 0) begin
                n_infetch[pick] = 1'b1; m_fack[pick] = 1'b1;
                m_owner = pick; m_fquad = pick; m_fptr = (pick + 1) % NQ;
            end
        end else if (fdn) begin
            n_infetch[m_owner] = 1'b0;
            m_fcmpl[m_owner] = 1'b1;
            m_owner = -1;
        end
        for (int q = 0; q < NQ; q++) begin
            m_has[q] = n_has[q]; m_started[q] = n_started[q];
            m_infetch[q] = n_infetch[q]; m_retire[q] = n_retire[q];
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 8'h11, 1'b1, 4'b0001};
        vecs[1] = '{1'b1, 8'h22, 1'b1, 4'b0011};
        vecs[2] = '{1'b1, 8'h33, 1'b1, 4'b0111};
        vecs[3] = '{1'b1, 8'h44, 1'b1, 4'b1111};
        vecs[4] = '{1'b1, 8'h55, 1'b0, 4'b1111};

        rst = 1'b0;
        idle_inputs();
        repeat (3) tick();
        chk("rst_ready", 128'(bus4.job_in_ready), 128'(0));
        chk("rst_busy", 128'(bus4.busy), 128'(0));
        chk("rst_start", 128'(bus4.job_start), 128'(0));
        chk("rst_count", 128'(bus4.jobs_done_count), 128'(0));
        chk("rst_fvalid", 128'(bus4.fetch_req_valid), 128'(0));
        rst = 1'b1;
        tick();

        // four back-to-back jobs fill the quads in order
        for (int i = 0; i < 5; i++) begin
            chk("disp_ready", 128'(bus4.job_in_ready), 128'(vecs[i].exp_ready));
            bus4.job_in_valid = vecs[i].valid;
            bus4.job_in_data  = PW'(vecs[i].data);
            tick();
            chk("disp_start", 128'(bus4.job_start), 128'(vecs[i].exp_start));
        end
        bus4.job_in_valid = 1'b0;
        for (int q = 0; q < NQ; q++)
            chk("disp_param", bus4.job_parameters[q*PW +: PW], 128'(17 * (q + 1)));
        chk("disp_full_ready", 128'(bus4.job_in_ready), 128'(0));

        // quad 3 holds off accept for 10 cycles
        bus4.job_accept = 4'b0111;
        tick();
        bus4.job_accept = 4'b0000;
        chk("acc_start", 128'(bus4.job_start), 128'(4'b1000));
        for (int i = 0; i < 10; i++) begin
            chk("q3_start_held", 128'(bus4.job_start[3]), 128'(1));
            chk("q3_param_stable", bus4.job_parameters[3*PW +: PW], 128'(8'h44));
            tick();
        end
        bus4.job_accept = 4'b1000;
        tick();
        bus4.job_accept = 4'b0000;
        chk("q3_run_start", 128'(bus4.job_start), 128'(0));
        chk("q3_run_busy", 128'(bus4.busy), 128'(1));

        // quads 1 and 2 request fetch together
        bus4.job_fetch_request = 4'b0110;
        tick();
        chk("f1_ack", 128'(bus4.job_fetch_ack), 128'(4'b0010));
        chk("f1_valid", 128'(bus4.fetch_req_valid), 128'(1));
        chk("f1_quad", 128'(bus4.fetch_req_quad), 128'(1));
        bus4.job_fetch_request = 4'b0100;
        tick();
        chk("f1_hold_ack", 128'(bus4.job_fetch_ack), 128'(0));
        chk("f1_hold_valid", 128'(bus4.fetch_req_valid), 128'(1));
        bus4.fetch_done = 1'b1;
        tick();
        bus4.fetch_done = 1'b0;
        chk("f1_cmpl", 128'(bus4.job_fetch_complete), 128'(4'b0010));
        chk("f_gap_valid", 128'(bus4.fetch_req_valid), 128'(0));
        chk("f_gap_ack", 128'(bus4.job_fetch_ack), 128'(0));
        tick();
        chk("f2_ack", 128'(bus4.job_fetch_ack), 128'(4'b0100));
        chk("f2_valid", 128'(bus4.fetch_req_valid), 128'(1));
        chk("f2_quad", 128'(bus4.fetch_req_quad), 128'(2));
        chk("f2_cmpl_clear", 128'(bus4.job_fetch_complete), 128'(0));
        bus4.job_fetch_request = 4'b0000;
        bus4.fetch_done = 1'b1;
        tick();
        bus4.fetch_done = 1'b0;
        chk("f2_cmpl", 128'(bus4.job_fetch_complete), 128'(4'b0100));
        chk("f2_drop", 128'(bus4.fetch_req_valid), 128'(0));

        // completion and fetch request together on quad 0
        chk("c0_count_before", 128'(bus4.jobs_done_count), 128'(0));
        bus4.job_complete = 4'b0001;
        bus4.job_fetch_request = 4'b0001;
        tick();
        bus4.job_complete = 4'b0000;
        bus4.job_fetch_request = 4'b0000;
        chk("c0_ack", 128'(bus4.job_complete_ack), 128'(4'b0001));
        chk("c0_no_fack", 128'(bus4.job_fetch_ack), 128'(0));
        chk("c0_no_fvalid", 128'(bus4.fetch_req_valid), 128'(0));
        chk("c0_count", 128'(bus4.jobs_done_count), 128'(1));
        tick();
        chk("c0_ack_pulse", 128'(bus4.job_complete_ack), 128'(0));
        chk("c0_free_ready", 128'(bus4.job_in_ready), 128'(1));

        // reset while quad 1 owns the fetch channel
        bus4.job_fetch_request = 4'b0010;
        tick();
        bus4.job_fetch_request = 4'b0000;
        chk("r_fvalid_pre", 128'(bus4.fetch_req_valid), 128'(1));
        #2 rst = 1'b0;
        #1;
        chk("r_fvalid", 128'(bus4.fetch_req_valid), 128'(0));
        chk("r_fquad", 128'(bus4.fetch_req_quad), 128'(0));
        chk("r_start", 128'(bus4.job_start), 128'(0));
        chk("r_params", 128'(|bus4.job_parameters), 128'(0));
        chk("r_count", 128'(bus4.jobs_done_count), 128'(0));
        chk("r_busy", 128'(bus4.busy), 128'(0));
        chk("r_ready", 128'(bus4.job_in_ready), 128'(0));
        chk("r_pulses", 128'({bus4.job_fetch_ack, bus4.job_fetch_complete, bus4.job_complete_ack}), 128'(0));
        bus4.fetch_done = 1'b1;
        tick();
        bus4.fetch_done = 1'b0;
        chk("r_no_fcmpl", 128'(bus4.job_fetch_complete), 128'(0));
        chk("r_fvalid_low", 128'(bus4.fetch_req_valid), 128'(0));

        // release: first dispatch on the second rising edge
        #2 rst = 1'b1;
        bus4.job_in_valid = 1'b1;
        bus4.job_in_data  = PW'(8'h99);
        #1;
        chk("rel_ready0", 128'(bus4.job_in_ready), 128'(0));
        tick();
        chk("rel_ready1", 128'(bus4.job_in_ready), 128'(1));
        chk("rel_start1", 128'(bus4.job_start), 128'(0));
        tick();
        bus4.job_in_valid = 1'b0;
        chk("rel_start2", 128'(bus4.job_start), 128'(4'b0001));
        chk("rel_param", bus4.job_parameters[0 +: PW], 128'(8'h99));

        // single-quad: freed quad is not reusable in its retire cycle
        bus1.job_in_valid = 1'b1;
        bus1.job_in_data  = 16'h00A1;
        tick();
        bus1.job_in_valid = 1'b0;
        chk("s_start", 128'(bus1.job_start), 128'(1));
        bus1.job_accept = 1'b1;
        tick();
        bus1.job_accept = 1'b0;
        chk("s_run", 128'(bus1.job_start), 128'(0));
        bus1.job_complete = 1'b1;
        bus1.job_in_valid = 1'b1;
        bus1.job_in_data  = 16'h00B2;
        chk("s_ready_cmpl", 128'(bus1.job_in_ready), 128'(0));
        tick();
        bus1.job_complete = 1'b0;
        chk("s_ack", 128'(bus1.job_complete_ack), 128'(1));
        chk("s_ready_ack", 128'(bus1.job_in_ready), 128'(0));
        chk("s_count", 128'(bus1.jobs_done_count), 128'(1));
        tick();
        chk("s_ready_free", 128'(bus1.job_in_ready), 128'(1));
        chk("s_not_taken", 128'(bus1.job_start), 128'(0));
        tick();
        bus1.job_in_valid = 1'b0;
        chk("s_taken", 128'(bus1.job_start), 128'(1));
        chk("s_param", 128'(bus1.job_parameters), 128'(16'h00B2));

        // random traffic against the reference model
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
        tick();
        model_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit            e_ready;
            bit            e_busy;
            bit [NQ-1:0]   e_start;
            bit            iv;
            bit            fdn;
            logic [PW-1:0] idata;
            bit [NQ-1:0]   acc, frq, cmp;
            e_ready = 1'b0; e_busy = 1'b0; e_start = '0;
            for (int q = 0; q < NQ; q++) begin
                if (!m_has[q]) e_ready = 1'b1;
                if (m_has[q]) e_busy = 1'b1;
                e_start[q] = m_has[q] && !m_started[q];
                chk("rnd_param", bus4.job_parameters[q*PW +: PW], m_param[q]);
            end
            chk("rnd_ready", 128'(bus4.job_in_ready), 128'(e_ready));
            chk("rnd_busy", 128'(bus4.busy), 128'(e_busy));
            chk("rnd_start", 128'(bus4.job_start), 128'(e_start));
            chk("rnd_fack", 128'(bus4.job_fetch_ack), 128'(m_fack));
            chk("rnd_fcmpl", 128'(bus4.job_fetch_complete), 128'(m_fcmpl));
            chk("rnd_cack", 128'(bus4.job_complete_ack), 128'(m_cack));
            chk("rnd_fvalid", 128'(bus4.fetch_req_valid), 128'(m_owner >= 0));
            if (m_owner >= 0) chk("rnd_fquad", 128'(bus4.fetch_req_quad), 128'(m_fquad));
            chk("rnd_count", 128'(bus4.jobs_done_count), 128'(m_count));

            iv    = ($urandom_range(0, 9) < 6);
            idata = {$urandom(), $urandom(), $urandom(), $urandom()};
            for (int q = 0; q < NQ; q++) begin
                acc[q] = 1'($urandom_range(0, 1));
                frq[q] = 1'($urandom_range(0, 1));
                cmp[q] = ($urandom_range(0, 9) == 0);
            end
            fdn = ($urandom_range(0, 9) < 3);
            bus4.job_in_valid      = iv;
            bus4.job_in_data       = idata;
            bus4.job_accept        = acc;
            bus4.job_fetch_request = frq;
            bus4.job_complete      = cmp;
            bus4.fetch_done        = fdn;
            model_step(iv, idata, acc, frq, cmp, fdn);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
